// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin share of the register-bank write port between the
//            ALU and memory writeback paths, plus a pending-write scoreboard
//            that raises the issue stall on RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int SIZE = 32,
    parameter int NREG = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_reg,
    input  logic [4:0]      src_a,
    input  logic [4:0]      src_b,
    output logic            stall,
    input  logic            req0_valid,
    input  logic [4:0]      req0_reg,
    input  logic [SIZE-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_reg,
    input  logic [SIZE-1:0] req1_data,
    output logic            req1_ready,
    output logic            RegWrite,
    output logic [4:0]      WriteReg,
    output logic [SIZE-1:0] WriteData,
    output logic [NREG-1:0] busy
);

    localparam logic [4:0] c_REG_ZERO = 5'd0;

    logic            r_last_grant;
    logic            r_regwrite;
    logic [4:0]      r_writereg;
    logic [SIZE-1:0] r_writedata;
    logic [NREG-1:0] r_busy;

    logic            w_grant0;
    logic            w_grant1;
    logic [4:0]      w_sel_reg;
    logic [SIZE-1:0] w_sel_data;
    logic            w_hit_a;
    logic            w_hit_b;
    logic            w_hit_d;
    logic            w_issue_accept;
    logic [NREG-1:0] w_busy_next;

    // On contention the requester not named by r_last_grant wins.
    assign w_grant0 = !reset && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = !reset && req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_sel_reg  = w_grant1 ? req1_reg  : req0_reg;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    // Register 0 is never reserved, so it is masked out of every hazard test.
    assign w_hit_a = (src_a     != c_REG_ZERO) && r_busy[src_a];
    assign w_hit_b = (src_b     != c_REG_ZERO) && r_busy[src_b];
    assign w_hit_d = (issue_reg != c_REG_ZERO) && r_busy[issue_reg];

    assign stall          = issue_valid && (w_hit_a || w_hit_b || w_hit_d);
    assign w_issue_accept = issue_valid && !stall && (issue_reg != c_REG_ZERO);

    // Clear is applied before set so a forced collision leaves the bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (r_regwrite) begin
            w_busy_next[r_writereg] = 1'b0;
        end
        if (w_issue_accept) begin
            w_busy_next[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_regwrite   <= 1'b0;
            r_writereg   <= 5'd0;
            r_writedata  <= '0;
            r_busy       <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_regwrite <= 1'b0;
            if (w_grant0 || w_grant1) begin
                r_last_grant <= w_grant1;
                if (w_sel_reg != c_REG_ZERO) begin
                    r_regwrite  <= 1'b1;
                    r_writereg  <= w_sel_reg;
                    r_writedata <= w_sel_data;
                end
            end
        end
    end

    assign RegWrite  = r_regwrite;
    assign WriteReg  = r_writereg;
    assign WriteData = r_writedata;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int SIZE = 32;
    localparam int NREG = 32;

    logic            clock;
    logic            reset;
    logic            issue_valid;
    logic [4:0]      issue_reg;
    logic [4:0]      src_a;
    logic [4:0]      src_b;
    logic            stall;
    logic            req0_valid;
    logic [4:0]      req0_reg;
    logic [SIZE-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [4:0]      req1_reg;
    logic [SIZE-1:0] req1_data;
    logic            req1_ready;
    logic            RegWrite;
    logic [4:0]      WriteReg;
    logic [SIZE-1:0] WriteData;
    logic [NREG-1:0] busy;

    int n_checks;
    int n_errors;

    regfile_write_arbiter #(
        .SIZE(SIZE),
        .NREG(NREG)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .src_a       (src_a),
        .src_b       (src_b),
        .stall       (stall),
        .req0_valid  (req0_valid),
        .req0_reg    (req0_reg),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_reg    (req1_reg),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_reg   = 5'd0;
        src_a       = 5'd0;
        src_b       = 5'd0;
        req0_valid  = 1'b0;
        req0_reg    = 5'd0;
        req0_data   = '0;
        req1_valid  = 1'b0;
        req1_reg    = 5'd0;
        req1_data   = '0;
    endtask

    logic [4:0]  exp_wreg [4];
    logic [31:0] exp_wdat [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_wreg[0] = 5'd3;  exp_wreg[1] = 5'd4;  exp_wreg[2] = 5'd3;  exp_wreg[3] = 5'd4;
        exp_wdat[0] = 32'h11; exp_wdat[1] = 32'h22; exp_wdat[2] = 32'h11; exp_wdat[3] = 32'h22;

        // Reset held two cycles with live requests.
        idle_inputs();
        reset       = 1'b1;
        req0_valid  = 1'b1;
        req0_reg    = 5'd7;
        req0_data   = 32'h1234;
        issue_valid = 1'b1;
        issue_reg   = 5'd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_eq("rst_ready0", req0_ready, 0);
            check_eq("rst_ready1", req1_ready, 0);
            check_eq("rst_regwrite", RegWrite, 0);
            check_eq("rst_busy", busy, 0);
        end
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        check_eq("rel_regwrite", RegWrite, 0);
        check_eq("rel_writereg", WriteReg, 0);
        check_eq("rel_writedata", WriteData, 0);
        check_eq("rel_busy", busy, 0);

        // Single write from the ALU path.
        step();
        req0_valid = 1'b1;
        req0_reg   = 5'd5;
        req0_data  = 32'hDEADBEEF;
        @(negedge clock);
        check_eq("single_ready0", req0_ready, 1);
        check_eq("single_ready1", req1_ready, 0);
        step();
        idle_inputs();
        @(negedge clock);
        check_eq("single_regwrite", RegWrite, 1);
        check_eq("single_writereg", WriteReg, 5);
        check_eq("single_writedata", WriteData, 32'hDEADBEEF);
        step();
        @(negedge clock);
        check_eq("single_regwrite_off", RegWrite, 0);
        check_eq("single_data_hold", WriteData, 32'hDEADBEEF);

        // Contention from a fresh reset: grants alternate starting with req0.
        step();
        reset = 1'b1;
        @(negedge clock);
        step();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req0_reg   = 5'd3;
        req0_data  = 32'h11;
        req1_valid = 1'b1;
        req1_reg   = 5'd4;
        req1_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            @(negedge clock);
            check_eq($sformatf("cont_ready0_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("cont_ready1_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                check_eq($sformatf("cont_regwrite_%0d", i), RegWrite, 1);
                check_eq($sformatf("cont_writereg_%0d", i), WriteReg, exp_wreg[i-1]);
                check_eq($sformatf("cont_writedata_%0d", i), WriteData, exp_wdat[i-1]);
            end
        end
        step();
        idle_inputs();
        @(negedge clock);
        check_eq("cont_regwrite_3", RegWrite, 1);
        check_eq("cont_writereg_3", WriteReg, exp_wreg[3]);
        check_eq("cont_writedata_3", WriteData, exp_wdat[3]);

        // Scoreboard: reserve r17, stall on RAW/WAW, release on writeback.
        step();
        issue_valid = 1'b1;
        issue_reg   = 5'd17;
        @(negedge clock);
        check_eq("sb_issue_nostall", stall, 0);
        step();
        idle_inputs();
        @(negedge clock);
        check_eq("sb_busy_set", busy, 32'h0002_0000);
        step();
        issue_valid = 1'b1;
        issue_reg   = 5'd0;
        src_a       = 5'd17;
        @(negedge clock);
        check_eq("sb_stall_src_a", stall, 1);
        step();
        src_a       = 5'd0;
        src_b       = 5'd17;
        req1_valid  = 1'b1;
        req1_reg    = 5'd17;
        req1_data   = 32'hABCD;
        @(negedge clock);
        check_eq("sb_stall_src_b", stall, 1);
        check_eq("sb_req1_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        src_b      = 5'd0;
        issue_reg  = 5'd17;
        @(negedge clock);
        check_eq("sb_wb_regwrite", RegWrite, 1);
        check_eq("sb_wb_writereg", WriteReg, 17);
        check_eq("sb_wb_writedata", WriteData, 32'hABCD);
        check_eq("sb_stall_waw", stall, 1);
        check_eq("sb_busy_still", busy, 32'h0002_0000);
        step();
        issue_valid = 1'b1;
        issue_reg   = 5'd0;
        src_a       = 5'd17;
        @(negedge clock);
        check_eq("sb_busy_clear", busy, 0);
        check_eq("sb_stall_clear", stall, 0);

        // Zero register: handshake completes but nothing is written or reserved.
        step();
        idle_inputs();
        req1_valid  = 1'b1;
        req1_reg    = 5'd0;
        req1_data   = 32'hFFFFFFFF;
        issue_valid = 1'b1;
        issue_reg   = 5'd0;
        @(negedge clock);
        check_eq("zero_req1_ready", req1_ready, 1);
        check_eq("zero_stall", stall, 0);
        step();
        idle_inputs();
        @(negedge clock);
        check_eq("zero_regwrite", RegWrite, 0);
        check_eq("zero_busy", busy, 0);

        // Reset mid-stream drops the pending reservation and the in-flight write.
        step();
        issue_valid = 1'b1;
        issue_reg   = 5'd9;
        @(negedge clock);
        step();
        idle_inputs();
        req0_valid = 1'b1;
        req0_reg   = 5'd12;
        req0_data  = 32'h55;
        @(negedge clock);
        check_eq("mid_busy9", busy, 32'h0000_0200);
        check_eq("mid_ready0", req0_ready, 1);
        step();
        reset      = 1'b1;
        req1_valid = 1'b1;
        req1_reg   = 5'd6;
        @(negedge clock);
        check_eq("mid_rst_ready0", req0_ready, 0);
        check_eq("mid_rst_ready1", req1_ready, 0);
        step();
        @(negedge clock);
        check_eq("mid_regwrite", RegWrite, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_writereg", WriteReg, 0);
        check_eq("mid_ready0_b", req0_ready, 0);
        check_eq("mid_ready1_b", req1_ready, 0);
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register bank between two writeback sources: req0 (ALU path) and req1 (memory/multi-cycle path). The port is granted round-robin and drives registered RegWrite/WriteReg/WriteData into the bank. A scoreboard of pending destination registers produces the issue-stage stall for RAW and WAW hazards. Sits between the execute/memory writeback stages and the register bank.

Parameters:
SIZE, 32, data width of WriteData and the request data ports.
NREG, 32, number of architectural registers. Register addresses are fixed at 5 bits.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
issue_valid  in  1  an instruction is trying to issue.
issue_reg  in  5  destination register of the issuing instruction.
src_a  in  5  first source register of the issuing instruction.
src_b  in  5  second source register of the issuing instruction.
stall  out  1  issue must hold this cycle (combinational).
req0_valid  in  1  ALU writeback request.
req0_reg  in  5  ALU writeback destination.
req0_data  in  SIZE  ALU writeback data.
req0_ready  out  1  req0 granted this cycle.
req1_valid  in  1  memory writeback request.
req1_reg  in  5  memory writeback destination.
req1_data  in  SIZE  memory writeback data.
req1_ready  out  1  req1 granted this cycle.
RegWrite  out  1  write enable to the register bank (registered).
WriteReg  out  5  write address to the register bank (registered).
WriteData  out  SIZE  write data to the register bank (registered).
busy  out  NREG  scoreboard; bit i = write to register i is pending.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, busy=0, last_grant=1 (so req0 wins the first contest).
- While reset is high: req0_ready=0 and req1_ready=0, and all requests are ignored.
- Handshake: a transfer occurs when valid && ready.
  - ready is combinational from the valid inputs and last_grant.
  - Requesters must hold valid, reg and data stable until they see ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not named by last_grant.
  - On any grant, last_grant <= granted index.
  - Neither valid: no grant, last_grant unchanged.
- Write latency: a grant in cycle t causes RegWrite=1, WriteReg=req_reg and WriteData=req_data during cycle t+1, for exactly one cycle per grant.
  - No grant in cycle t: RegWrite=0 in t+1. WriteReg and WriteData hold their previous values.
- Register 0: a grant whose reg is 0 completes the handshake (ready=1) but produces RegWrite=0. Register 0 is never written.
- Scoreboard:
  - Issue is accepted when issue_valid && !stall && issue_reg!=0. On that edge, busy[issue_reg] <= 1.
  - On every edge where RegWrite=1, busy[WriteReg] <= 0. This is the same edge on which the bank latches the data.
  - Set and clear of the same register on the same edge cannot occur, because a busy destination stalls issue. If it is forced anyway, set wins.
  - Clears of different registers are independent of a simultaneous set.
- Stall logic:
  - stall = issue_valid && (busy[src_a] || busy[src_b] || busy[issue_reg]).
  - Register 0 never contributes to stall.
  - stall is computed from the registered busy state only, with no same-cycle bypass. It therefore deasserts the cycle after the RegWrite cycle.
- Writebacks with an unreserved reg: allowed. The clear of an already-0 bit is a no-op.
- Reset mid-operation: in-flight grants and pending busy bits are dropped. The next cycle shows the reset values.

Test Plan:
- Reset: hold reset 2 cycles with req0_valid=1 and issue_valid=1 -> ready=0, RegWrite=0, busy=0 throughout and on the first cycle after release.
- Single write: req0_valid=1, req0_reg=5, req0_data=0xDEADBEEF in cycle t -> req0_ready=1 in t; RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in t+1; RegWrite=0 in t+2.
- Contention: req0 (reg 3, data 0x11) and req1 (reg 4, data 0x22) both held valid for 4 cycles from reset -> grants 0,1,0,1; WriteReg sequence 3,4,3,4 one cycle later.
- Scoreboard: issue reg 17 -> busy[17]=1 next cycle; then src_a=17 with issue_valid -> stall=1; req1 writes reg 17 -> RegWrite cycle; busy[17]=0 and stall=0 the following cycle.
- Zero register: req1_reg=0, data 0xFFFFFFFF -> req1_ready=1, RegWrite stays 0; issue_reg=0 -> busy unchanged and stall=0.
- Reset mid-stream: busy[9]=1 and req0 granted in cycle t, reset in t+1 -> in t+2 RegWrite=0, busy=0, both ready=0 while reset is high.
